// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the PC sequencer: redirect kinds, FSM states, alignment modes.
package pc_pkg;

    typedef enum logic [1:0] {
        KIND_BRANCH = 2'b00,
        KIND_JAL    = 2'b01,
        KIND_JALR   = 2'b10,
        KIND_TRAP   = 2'b11
    } redirect_kind_e;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FAULT = 2'b10
    } state_e;

    localparam int unsigned IALIGN_32 = 32;
    localparam int unsigned IALIGN_16 = 16;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/redirect inputs and fetch-side outputs of the PC sequencer.
interface pc_sequencer_if
    import pc_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned CNT_WIDTH = 32
);
    logic                 stall;
    logic                 redirect_valid;
    redirect_kind_e       redirect_kind;
    logic                 branch_taken;
    logic [XLEN-1:0]      imm;
    logic [XLEN-1:0]      rs1;
    logic [XLEN-1:0]      trap_vector;
    logic                 fetch_ready;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      pc_plus4;
    logic                 fetch_valid;
    logic                 misaligned;
    logic [XLEN-1:0]      fault_addr;
    logic [CNT_WIDTH-1:0] fetch_count;

    modport master (
        output stall, redirect_valid, redirect_kind, branch_taken,
               imm, rs1, trap_vector, fetch_ready,
        input  pc, pc_plus4, fetch_valid, misaligned, fault_addr, fetch_count
    );

    modport slave (
        input  stall, redirect_valid, redirect_kind, branch_taken,
               imm, rs1, trap_vector, fetch_ready,
        output pc, pc_plus4, fetch_valid, misaligned, fault_addr, fetch_count
    );

endinterface

// File: rtl/pc_sequencer_target_calc.sv
// Combinational redirect-target computation and alignment check.
module pc_target_calc
    import pc_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned IALIGN = 32
) (
    input  logic [XLEN-1:0] pc_i,
    input  redirect_kind_e  kind_i,
    input  logic            taken_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] trap_vector_i,
    output logic [XLEN-1:0] target_c_o,
    output logic            misaligned_c_o
);

    // Low address bits that must be zero for a legal instruction address.
    localparam logic [XLEN-1:0] ALIGN_MASK = (IALIGN == IALIGN_16) ? XLEN'(1) : XLEN'(3);

    // Target select per redirect kind; all sums wrap at 2^XLEN.
    always_comb begin
        target_c_o = pc_i + XLEN'(4);
        case (kind_i)
            KIND_BRANCH: if (taken_i) target_c_o = pc_i + imm_i;
            KIND_JAL:    target_c_o = pc_i + imm_i;
            KIND_JALR:   target_c_o = (rs1_i + imm_i) & ~XLEN'(1);
            KIND_TRAP:   target_c_o = trap_vector_i & ~XLEN'(3);
            default:     target_c_o = pc_i + XLEN'(4);
        endcase
    end

    // Trap targets are forced aligned above, so they can never fault.
    assign misaligned_c_o = (kind_i != KIND_TRAP) && (|(target_c_o & ALIGN_MASK));

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: boot, sequential fetch, redirects and misalignment fault.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned    XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
    parameter int unsigned    IALIGN       = 32,
    parameter int unsigned    CNT_WIDTH    = 32
) (
    input logic           clock,
    input logic           reset_n,
    pc_sequencer_if.slave bus
);

    state_e               state_q, state_d;
    logic [XLEN-1:0]      pc_q, pc_d;
    logic [XLEN-1:0]      fault_addr_q, fault_addr_d;
    logic                 fetch_valid_q, fetch_valid_d;
    logic                 misaligned_q, misaligned_d;
    logic [CNT_WIDTH-1:0] fetch_count_q, fetch_count_d;

    logic [XLEN-1:0]      target_c;
    logic                 target_misaligned_c;
    logic                 is_trap_c;
    logic                 handshake_c;

    pc_target_calc #(
        .XLEN   (XLEN),
        .IALIGN (IALIGN)
    ) u_target_calc (
        .pc_i           (pc_q),
        .kind_i         (bus.redirect_kind),
        .taken_i        (bus.branch_taken),
        .imm_i          (bus.imm),
        .rs1_i          (bus.rs1),
        .trap_vector_i  (bus.trap_vector),
        .target_c_o     (target_c),
        .misaligned_c_o (target_misaligned_c)
    );

    assign is_trap_c   = bus.redirect_valid && (bus.redirect_kind == KIND_TRAP);
    assign handshake_c = fetch_valid_q && bus.fetch_ready;

    // Next-state, next-pc and fault capture; redirect beats stall beats advance.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fault_addr_d  = fault_addr_q;
        misaligned_d  = 1'b0;
        fetch_count_d = handshake_c ? fetch_count_q + CNT_WIDTH'(1) : fetch_count_q;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (is_trap_c) begin
                    pc_d = target_c;
                end else if (bus.redirect_valid) begin
                    if (target_misaligned_c) begin
                        misaligned_d = 1'b1;
                        fault_addr_d = target_c;
                        state_d      = ST_FAULT;
                    end else begin
                        pc_d = target_c;
                    end
                end else if (!bus.stall && handshake_c) begin
                    pc_d = pc_q + XLEN'(4);
                end
            end
            ST_FAULT: begin
                if (is_trap_c) begin
                    pc_d    = target_c;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        fetch_valid_d = (state_d == ST_RUN);
    end

    // State, pc, fault and counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_VECTOR;
            fault_addr_q  <= '0;
            fetch_valid_q <= 1'b0;
            misaligned_q  <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fault_addr_q  <= fault_addr_d;
            fetch_valid_q <= fetch_valid_d;
            misaligned_q  <= misaligned_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_q + XLEN'(4);
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.misaligned  = misaligned_q;
    assign bus.fault_addr  = fault_addr_q;
    assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized run vs. a reference model.
module tb_pc_sequencer;
    import pc_pkg::*;

    logic clock;
    logic reset_n;

    pc_sequencer_if #(.XLEN(32), .CNT_WIDTH(32)) bus   ();
    pc_sequencer_if #(.XLEN(32), .CNT_WIDTH(32)) bus16 ();

    pc_sequencer #(
        .XLEN(32), .RESET_VECTOR(32'h0000_0000), .IALIGN(32), .CNT_WIDTH(32)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    pc_sequencer #(
        .XLEN(32), .RESET_VECTOR(32'h0000_0000), .IALIGN(16), .CNT_WIDTH(32)
    ) dut16 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus16.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model (IALIGN=32 instance): mode 0=boot, 1=run, 2=fault.
    logic [31:0] m_pc;
    logic [31:0] m_fault;
    logic [31:0] m_cnt;
    logic        m_mis;
    int          m_mode;

    task automatic model_reset;
        m_pc = 32'h0; m_fault = 32'h0; m_cnt = 32'h0; m_mis = 1'b0; m_mode = 0;
    endtask

    task automatic model_step;
        logic [31:0] t;
        logic        bad;
        if (m_mode == 1 && bus.fetch_ready) m_cnt = m_cnt + 32'd1;
        m_mis = 1'b0;
        case (bus.redirect_kind)
            KIND_BRANCH: t = bus.branch_taken ? m_pc + bus.imm : m_pc + 32'd4;
            KIND_JAL:    t = m_pc + bus.imm;
            KIND_JALR:   t = (bus.rs1 + bus.imm) & 32'hFFFF_FFFE;
            default:     t = bus.trap_vector & 32'hFFFF_FFFC;
        endcase
        bad = (bus.redirect_kind != KIND_TRAP) && (t % 32'd4 != 32'd0);
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (bus.redirect_valid) begin
                if (bad) begin
                    m_mis = 1'b1; m_fault = t; m_mode = 2;
                end else begin
                    m_pc = t;
                end
            end else if (!bus.stall && bus.fetch_ready) begin
                m_pc = m_pc + 32'd4;
            end
        end else if (bus.redirect_valid && bus.redirect_kind == KIND_TRAP) begin
            m_pc = t; m_mode = 1;
        end
    endtask

    task automatic set_idle;
        bus.stall = 0; bus.redirect_valid = 0; bus.redirect_kind = KIND_BRANCH;
        bus.branch_taken = 0; bus.imm = '0; bus.rs1 = '0; bus.trap_vector = '0;
        bus.fetch_ready = 0;
        bus16.stall = 0; bus16.redirect_valid = 0; bus16.redirect_kind = KIND_BRANCH;
        bus16.branch_taken = 0; bus16.imm = '0; bus16.rs1 = '0; bus16.trap_vector = '0;
        bus16.fetch_ready = 0;
    endtask

    task automatic redirect(input redirect_kind_e k, input logic tk, input logic [31:0] im,
                            input logic [31:0] r1, input logic [31:0] tv);
        bus.redirect_valid = 1; bus.redirect_kind = k; bus.branch_taken = tk;
        bus.imm = im; bus.rs1 = r1; bus.trap_vector = tv;
    endtask

    task automatic tick;
        model_step();
        @(posedge clock);
        #1;
    endtask

    // Drops reset asynchronously, checks the forced values, releases at the falling edge.
    task automatic do_reset;
        reset_n = 1'b0;
        set_idle();
        #2;
        model_reset();
        n_tests++;
        if (bus.pc !== 32'h0 || bus.fetch_valid !== 1'b0 || bus.misaligned !== 1'b0 ||
            bus.fault_addr !== 32'h0 || bus.fetch_count !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: pc=%h fv=%b mis=%b fault=%h cnt=%0d, required pc=0 fv=0 mis=0 fault=0 cnt=0",
                     bus.pc, bus.fetch_valid, bus.misaligned, bus.fault_addr, bus.fetch_count);
        end
        @(negedge clock);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        do_reset();
        tick();
        n_tests++;
        if (bus.fetch_valid !== 1'b1 || bus.pc !== 32'h0) begin
            n_fail++;
            $display("FAIL boot_to_run: fv=%b pc=%h, required fv=1 pc=0", bus.fetch_valid, bus.pc);
        end
    endtask

    task automatic test_sequential;
        do_reset();
        tick();
        bus.fetch_ready = 1;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (bus.pc !== 32'(4 * i)) begin
                n_fail++;
                $display("FAIL seq_pc[%0d]: pc=%h, required %h", i, bus.pc, 32'(4 * i));
            end
            tick();
        end
        bus.fetch_ready = 0;
        n_tests++;
        if (bus.fetch_count !== 32'd4 || bus.pc !== 32'h10) begin
            n_fail++;
            $display("FAIL seq_count: cnt=%0d pc=%h, required cnt=4 pc=10", bus.fetch_count, bus.pc);
        end
    endtask

    task automatic test_branch;
        redirect(KIND_BRANCH, 1'b1, 32'hFFFF_FFF8, 32'h0, 32'h0);
        tick();
        n_tests++;
        if (bus.pc !== 32'h08 || bus.fetch_valid !== 1'b1 || bus.misaligned !== 1'b0) begin
            n_fail++;
            $display("FAIL branch_taken: pc=%h fv=%b mis=%b, required pc=08 fv=1 mis=0",
                     bus.pc, bus.fetch_valid, bus.misaligned);
        end
        redirect(KIND_JAL, 1'b0, 32'h8, 32'h0, 32'h0);
        tick();
        redirect(KIND_BRANCH, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h0);
        tick();
        set_idle();
        n_tests++;
        if (bus.pc !== 32'h14) begin
            n_fail++;
            $display("FAIL branch_not_taken: pc=%h, required 14", bus.pc);
        end
    endtask

    task automatic test_jalr_fault;
        redirect(KIND_JALR, 1'b0, 32'h2, 32'h101, 32'h0);
        tick();
        set_idle();
        n_tests++;
        if (bus.misaligned !== 1'b1 || bus.fault_addr !== 32'h102 || bus.fetch_valid !== 1'b0 ||
            bus.pc !== 32'h14) begin
            n_fail++;
            $display("FAIL jalr_misaligned: mis=%b fault=%h fv=%b pc=%h, required mis=1 fault=102 fv=0 pc=14",
                     bus.misaligned, bus.fault_addr, bus.fetch_valid, bus.pc);
        end
        redirect(KIND_JAL, 1'b0, 32'h40, 32'h0, 32'h0);
        bus.fetch_ready = 1;
        tick();
        n_tests++;
        if (bus.misaligned !== 1'b0 || bus.pc !== 32'h14 || bus.fetch_valid !== 1'b0 ||
            bus.fetch_count !== m_cnt) begin
            n_fail++;
            $display("FAIL fault_ignores_jal: mis=%b pc=%h fv=%b cnt=%0d, required mis=0 pc=14 fv=0 cnt=%0d",
                     bus.misaligned, bus.pc, bus.fetch_valid, bus.fetch_count, m_cnt);
        end
        set_idle();
        redirect(KIND_TRAP, 1'b0, 32'h0, 32'h0, 32'h203);
        tick();
        set_idle();
        n_tests++;
        if (bus.pc !== 32'h200 || bus.fetch_valid !== 1'b1 || bus.fault_addr !== 32'h102) begin
            n_fail++;
            $display("FAIL trap_exit_fault: pc=%h fv=%b fault=%h, required pc=200 fv=1 fault=102",
                     bus.pc, bus.fetch_valid, bus.fault_addr);
        end
    endtask

    task automatic test_stall;
        redirect(KIND_TRAP, 1'b0, 32'h0, 32'h0, 32'h20);
        tick();
        set_idle();
        bus.stall = 1;
        redirect(KIND_JAL, 1'b0, 32'h40, 32'h0, 32'h0);
        tick();
        set_idle();
        n_tests++;
        if (bus.pc !== 32'h60) begin
            n_fail++;
            $display("FAIL stall_vs_jal: pc=%h, required 60", bus.pc);
        end
        redirect(KIND_TRAP, 1'b0, 32'h0, 32'h0, 32'h20);
        tick();
        set_idle();
        bus.stall = 1;
        bus.fetch_ready = 1;
        tick();
        tick();
        set_idle();
        n_tests++;
        if (bus.pc !== 32'h20 || bus.fetch_count !== m_cnt) begin
            n_fail++;
            $display("FAIL stall_hold: pc=%h cnt=%0d, required pc=20 cnt=%0d", bus.pc, bus.fetch_count, m_cnt);
        end
    endtask

    task automatic test_wrap;
        redirect(KIND_TRAP, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC);
        tick();
        set_idle();
        n_tests++;
        if (bus.pc !== 32'hFFFF_FFFC || bus.pc_plus4 !== 32'h0) begin
            n_fail++;
            $display("FAIL pc_plus4_wrap: pc=%h pc_plus4=%h, required FFFFFFFC and 0", bus.pc, bus.pc_plus4);
        end
        bus.fetch_ready = 1;
        tick();
        n_tests++;
        if (bus.pc !== 32'h0) begin
            n_fail++;
            $display("FAIL pc_wrap: pc=%h, required 0", bus.pc);
        end
        tick();
        bus.fetch_ready = 0;
        #3;
        n_tests++;
        if (bus.pc !== 32'h4) begin
            n_fail++;
            $display("FAIL pre_reset_pc: pc=%h, required 4", bus.pc);
        end
        do_reset();
    endtask

    task automatic test_ialign16;
        do_reset();
        tick();
        bus16.redirect_valid = 1; bus16.redirect_kind = KIND_JALR;
        bus16.rs1 = 32'h101; bus16.imm = 32'h2;
        tick();
        n_tests++;
        if (bus16.pc !== 32'h102 || bus16.fetch_valid !== 1'b1 || bus16.misaligned !== 1'b0) begin
            n_fail++;
            $display("FAIL ialign16_jalr: pc=%h fv=%b mis=%b, required pc=102 fv=1 mis=0",
                     bus16.pc, bus16.fetch_valid, bus16.misaligned);
        end
        bus16.redirect_kind = KIND_JAL; bus16.imm = 32'h1;
        tick();
        set_idle();
        n_tests++;
        if (bus16.misaligned !== 1'b1 || bus16.fault_addr !== 32'h103 || bus16.fetch_valid !== 1'b0 ||
            bus16.pc !== 32'h102) begin
            n_fail++;
            $display("FAIL ialign16_odd: mis=%b fault=%h fv=%b pc=%h, required mis=1 fault=103 fv=0 pc=102",
                     bus16.misaligned, bus16.fault_addr, bus16.fetch_valid, bus16.pc);
        end
    endtask

    task automatic test_random;
        logic [31:0] im;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            set_idle();
            bus.stall       = ($urandom_range(0, 3) == 0);
            bus.fetch_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                im = 32'($urandom_range(0, 255)) - 32'd128;
                if ($urandom_range(0, 3) != 0) im[1:0] = 2'b00;
                redirect(redirect_kind_e'(2'($urandom_range(0, 3))), 1'($urandom_range(0, 1)),
                         im, $urandom, $urandom);
            end
            tick();
            n_tests++;
            if (bus.pc !== m_pc || bus.pc_plus4 !== m_pc + 32'd4) begin
                n_fail++;
                $display("FAIL rand_pc[%0d]: pc=%h pc_plus4=%h, required pc=%h pc_plus4=%h",
                         c, bus.pc, bus.pc_plus4, m_pc, m_pc + 32'd4);
            end
            n_tests++;
            if (bus.fetch_valid !== (m_mode == 1) || bus.misaligned !== m_mis ||
                bus.fault_addr !== m_fault || bus.fetch_count !== m_cnt) begin
                n_fail++;
                $display("FAIL rand_status[%0d]: fv=%b mis=%b fault=%h cnt=%0d, required fv=%b mis=%b fault=%h cnt=%0d",
                         c, bus.fetch_valid, bus.misaligned, bus.fault_addr, bus.fetch_count,
                         (m_mode == 1), m_mis, m_fault, m_cnt);
            end
        end
    endtask

    initial begin
        reset_n = 1'b1;
        set_idle();
        model_reset();
        #1;
        test_reset();
        test_sequential();
        test_branch();
        test_jalr_fault();
        test_stall();
        test_wrap();
        test_ialign16();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter XLEN, default 32, PC and operand width.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded on reset.
REQ-003 Parameter IALIGN, default 32, instruction alignment in bits; legal values 32 or 16.
REQ-004 Parameter CNT_WIDTH, default 32, width of the fetch counter.
REQ-005 The block SHALL have one clock and an asynchronous active-low reset; clock is named clock and reset is named reset_n.
REQ-006 clock  input  1  rising-edge clock.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 stall  input  1  hold PC; no sequential advance.
REQ-009 redirect_valid  input  1  redirect request this cycle.
REQ-010 redirect_kind  input  2  00 branch, 01 jal, 10 jalr, 11 trap.
REQ-011 branch_taken  input  1  branch outcome; used only when kind=00.
REQ-012 imm  input  XLEN  sign-extended immediate.
REQ-013 rs1  input  XLEN  jalr base register value.
REQ-014 trap_vector  input  XLEN  trap target.
REQ-015 fetch_ready  input  1  fetch side accepts current PC.
REQ-016 pc  output  XLEN  current fetch address.
REQ-017 pc_plus4  output  XLEN  pc+4 modulo 2^XLEN, combinational (link value).
REQ-018 fetch_valid  output  1  pc is valid for fetch.
REQ-019 misaligned  output  1  one-cycle pulse on a misaligned redirect target.
REQ-020 fault_addr  output  XLEN  last misaligned target.
REQ-021 fetch_count  output  CNT_WIDTH  number of completed fetch handshakes.

Function
REQ-022 States SHALL be BOOT, RUN and FAULT; fetch_valid is 1 only in RUN.
REQ-023 BOOT SHALL transition to RUN unconditionally after one cycle.
REQ-024 Redirect targets SHALL be: branch taken pc+imm; branch not taken pc+4; jal pc+imm; jalr (rs1+imm) with bit 0 cleared; trap trap_vector with bits [1:0] cleared; all arithmetic modulo 2^XLEN.
REQ-025 A target SHALL be misaligned when bits [1:0]!=0 for IALIGN=32, or bit 0!=0 for IALIGN=16; trap targets are never misaligned.
REQ-026 In RUN, a redirect with an aligned target SHALL load pc at that edge; the new pc and fetch_valid=1 are visible the next cycle (latency 1).
REQ-027 In RUN, a redirect with a misaligned target SHALL leave pc unchanged, pulse misaligned for one cycle, load fault_addr with the target, and enter FAULT.
REQ-028 In FAULT, all inputs except a trap redirect SHALL be ignored; a trap redirect loads pc and returns to RUN.
REQ-029 Priority in RUN SHALL be: trap redirect > other redirect > stall > sequential advance.
REQ-030 Sequential advance SHALL occur when fetch_valid && fetch_ready && !stall && !redirect_valid: pc <= pc+4.
REQ-031 fetch_count SHALL increment on each cycle with fetch_valid && fetch_ready, regardless of stall or redirect, and wrap silently at 2^CNT_WIDTH.
REQ-032 pc SHALL wrap from 2^XLEN-4 to 0 without any flag.
REQ-033 A redirect in BOOT SHALL be ignored.

Reset
REQ-034 Asserting reset_n low SHALL immediately force pc=RESET_VECTOR, state=BOOT, fetch_valid=0, misaligned=0, fault_addr=0, fetch_count=0, including mid-redirect or while in FAULT.
REQ-035 After reset_n rises, the first rising edge SHALL move BOOT to RUN.

Structure
REQ-036 Package pc_pkg SHALL hold the redirect_kind encodings, the state encoding and the IALIGN legal values.
REQ-037 Target computation and the alignment check SHALL be a combinational sub-module, pc_target_calc; state, pc and counter registers remain in pc_sequencer.

Verification
REQ-038 Reset, then fetch_ready=1 for 4 cycles -> pc 0,4,8,C; fetch_count=4.
REQ-039 At pc=0x10, branch taken with imm=0xFFFFFFF8 -> pc=0x08 next cycle; not-taken variant -> pc=0x14.
REQ-040 jalr with rs1=0x101, imm=0x2 -> pc=0x102 (IALIGN=16) or misaligned pulse with fault_addr=0x102, FAULT state, fetch_valid=0 (IALIGN=32).
REQ-041 In FAULT, jal is ignored; trap with trap_vector=0x203 -> pc=0x200, fetch_valid=1.
REQ-042 stall=1 and jal imm=0x40 simultaneously at pc=0x20 -> pc=0x60; stall alone -> pc held at 0x20.
REQ-043 pc=0xFFFFFFFC with advance -> pc=0; reset_n pulsed low mid-cycle -> pc=RESET_VECTOR immediately.
